// File: rtl/sipo_word_collector_if.sv
// Output word stream of the serial-to-parallel collector.
// dout is only meaningful while dout_valid=1; a word moves when dout_valid & dout_ready are both high at a rising edge.
interface sipo_word_collector_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;

  modport master (
    output dout,
    output dout_valid,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    output dout_ready
  );
endinterface

// File: rtl/sipo_word_collector.sv
// Reassembles an MSB-first serial bit stream into WIDTH-bit words.
// Finished words go through a first-word-fall-through FIFO with a sticky drop flag.
module sipo_word_collector #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  input  logic                       sin_valid,
  input  logic                       sync,
  sipo_word_collector_if.master      out_if,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf,
  output logic [0:0]                 fsm_state
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] push_word;
  logic             push;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    lvl;
  logic             full, pop, push_ok, drop;

  assign push_word = {sh[WIDTH-2:0], sin};

  // A sync bit restarts the word and never completes one, even on the last bit slot.
  always_comb begin
    sh_n    = sh;
    cnt_n   = cnt;
    state_n = state;
    push    = 1'b0;
    if (sin_valid) begin
      if (sync) begin
        sh_n    = {{(WIDTH-1){1'b0}}, sin};
        cnt_n   = CW'(1);
        state_n = SHIFT;
      end else begin
        sh_n = push_word;
        if (cnt == CW'(WIDTH - 1)) begin
          push    = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n   = cnt + CW'(1);
          state_n = SHIFT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sh    <= sh_n;
      cnt   <= cnt_n;
    end
  end

  // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
  assign full    = (lvl == LW'(DEPTH));
  assign pop     = out_if.dout_valid & out_if.dout_ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)      lvl <= lvl + LW'(1);
      else if (pop && !push_ok) lvl <= lvl - LW'(1);
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign out_if.dout_valid = (lvl != '0);
  assign out_if.dout       = out_if.dout_valid ? mem[rd_ptr] : '0;
  assign busy              = (state == SHIFT);
  assign level             = lvl;
  assign fsm_state         = state;

endmodule

// File: tb/tb_sipo_word_collector.sv
// Directed vector table for sipo_word_collector (WIDTH=4, DEPTH=2), with a pop-order scoreboard
// and a hand-written asynchronous reset sequence in the middle of the table.
module tb_sipo_word_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sin = 1'b0, sin_valid = 1'b0, sync = 1'b0, clr_ovf = 1'b0;
  logic       busy, overflow;
  logic [1:0] level;
  logic [0:0] fsm_state;

  sipo_word_collector_if #(.WIDTH(4)) bus ();

  sipo_word_collector #(.WIDTH(4), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .sin_valid (sin_valid),
    .sync      (sync),
    .out_if    (bus),
    .busy      (busy),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v, s, y, r, c;
    logic [3:0] e_dout;
    logic       e_dv, e_busy;
    logic [1:0] e_lvl;
    logic       e_ovf;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         reset_at;

  task automatic add(input logic v, s, y, r, c, input logic [3:0] d,
                     input logic dv, b, input logic [1:0] l, input logic o);
    vec_t t;
    t.v = v; t.s = s; t.y = y; t.r = r; t.c = c;
    t.e_dout = d; t.e_dv = dv; t.e_busy = b; t.e_lvl = l; t.e_ovf = o;
    vecs.push_back(t);
  endtask

  task automatic step(input vec_t t, input int idx);
    logic [8:0] got, want;
    sin_valid = t.v; sin = t.s; sync = t.y; bus.dout_ready = t.r; clr_ovf = t.c;
    @(posedge clk);
    #1;
    got  = {bus.dout, bus.dout_valid, busy, level, overflow};
    want = {t.e_dout, t.e_dv, t.e_busy, t.e_lvl, t.e_ovf};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL vec%0d {dout,dv,busy,level,ovf}: got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b",
               idx, got[8:5], got[4], got[3], got[2:1], got[0],
               want[8:5], want[4], want[3], want[2:1], want[0]);
    end
  endtask

  // Scoreboard: every pop must deliver the next expected word in order.
  always @(posedge clk) begin
    if (reset && bus.dout_valid && bus.dout_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_order: got unexpected pop %h, want no pop", bus.dout);
      end else begin
        if (bus.dout !== exp_q[0]) begin
          errors++;
          $display("FAIL pop_order: got %h want %h", bus.dout, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.dout_ready = 1'b0;
    // Case 1: back-to-back bits 1,0,1,1 with ready high
    add(1,1,0,1,0, 4'h0,0,1,0,0);
    add(1,0,0,1,0, 4'h0,0,1,0,0);
    add(1,1,0,1,0, 4'h0,0,1,0,0);
    add(1,1,0,1,0, 4'hB,1,0,1,0);
    add(0,0,0,1,0, 4'h0,0,0,0,0);
    // Case 2: same word with 1..3 idle cycles between bits
    add(1,1,0,1,0, 4'h0,0,1,0,0);
    add(0,0,0,1,0, 4'h0,0,1,0,0);
    add(1,0,0,1,0, 4'h0,0,1,0,0);
    add(0,0,0,1,0, 4'h0,0,1,0,0);
    add(0,0,0,1,0, 4'h0,0,1,0,0);
    add(1,1,0,1,0, 4'h0,0,1,0,0);
    add(0,0,0,1,0, 4'h0,0,1,0,0);
    add(0,0,0,1,0, 4'h0,0,1,0,0);
    add(0,0,0,1,0, 4'h0,0,1,0,0);
    add(1,1,0,1,0, 4'hB,1,0,1,0);
    add(0,0,0,1,0, 4'h0,0,0,0,0);
    // Case 3: A, 5, C with ready low -> C dropped; drain; clear overflow
    add(1,1,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'h0,0,1,0,0);
    add(1,1,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'hA,1,0,1,0);
    add(1,0,0,0,0, 4'hA,1,1,1,0);
    add(1,1,0,0,0, 4'hA,1,1,1,0);
    add(1,0,0,0,0, 4'hA,1,1,1,0);
    add(1,1,0,0,0, 4'hA,1,0,2,0);
    add(1,1,0,0,0, 4'hA,1,1,2,0);
    add(1,1,0,0,0, 4'hA,1,1,2,0);
    add(1,0,0,0,0, 4'hA,1,1,2,0);
    add(1,0,0,0,0, 4'hA,1,0,2,1);
    add(0,0,0,1,0, 4'h5,1,0,1,1);
    add(0,0,0,1,0, 4'h0,0,0,0,1);
    add(0,0,0,0,1, 4'h0,0,0,0,0);
    // Case 4: fill with 9, 3; complete E on the same edge as a pop
    add(1,1,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'h0,0,1,0,0);
    add(1,1,0,0,0, 4'h9,1,0,1,0);
    add(1,0,0,0,0, 4'h9,1,1,1,0);
    add(1,0,0,0,0, 4'h9,1,1,1,0);
    add(1,1,0,0,0, 4'h9,1,1,1,0);
    add(1,1,0,0,0, 4'h9,1,0,2,0);
    add(1,1,0,0,0, 4'h9,1,1,2,0);
    add(1,1,0,0,0, 4'h9,1,1,2,0);
    add(1,1,0,0,0, 4'h9,1,1,2,0);
    add(1,0,0,1,0, 4'h3,1,0,2,0);
    add(0,0,0,1,0, 4'hE,1,0,1,0);
    add(0,0,0,1,0, 4'h0,0,0,0,0);
    // Case 5: 1,1 then sync on a 0, then 1,1,0 -> only 6
    add(1,1,0,1,0, 4'h0,0,1,0,0);
    add(1,1,0,1,0, 4'h0,0,1,0,0);
    add(1,0,1,1,0, 4'h0,0,1,0,0);
    add(1,1,0,1,0, 4'h0,0,1,0,0);
    add(1,1,0,1,0, 4'h0,0,1,0,0);
    add(1,0,0,1,0, 4'h6,1,0,1,0);
    add(0,0,0,1,0, 4'h0,0,0,0,0);
    // Case 6a: FIFO holds A, 5 and two bits are in flight when reset hits
    add(1,1,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'h0,0,1,0,0);
    add(1,1,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'hA,1,0,1,0);
    add(1,0,0,0,0, 4'hA,1,1,1,0);
    add(1,1,0,0,0, 4'hA,1,1,1,0);
    add(1,0,0,0,0, 4'hA,1,1,1,0);
    add(1,1,0,0,0, 4'hA,1,0,2,0);
    add(1,1,0,0,0, 4'hA,1,1,2,0);
    add(1,1,0,0,0, 4'hA,1,1,2,0);
    reset_at = vecs.size();
    // Case 6b: after reset, 0,0,1,1 -> 3; then F; then a drop coincident with clr_ovf
    add(1,0,0,0,0, 4'h0,0,1,0,0);
    add(1,0,0,0,0, 4'h0,0,1,0,0);
    add(1,1,0,0,0, 4'h0,0,1,0,0);
    add(1,1,0,0,0, 4'h3,1,0,1,0);
    add(1,1,0,0,0, 4'h3,1,1,1,0);
    add(1,1,0,0,0, 4'h3,1,1,1,0);
    add(1,1,0,0,0, 4'h3,1,1,1,0);
    add(1,1,0,0,0, 4'h3,1,0,2,0);
    add(1,0,0,0,0, 4'h3,1,1,2,0);
    add(1,0,0,0,0, 4'h3,1,1,2,0);
    add(1,0,0,0,0, 4'h3,1,1,2,0);
    add(1,0,0,0,1, 4'h3,1,0,2,1);
    add(0,0,0,0,1, 4'h3,1,0,2,0);
    add(0,0,0,1,0, 4'hF,1,0,1,0);
    add(0,0,0,1,0, 4'h0,0,0,0,0);

    exp_q = '{4'hB, 4'hB, 4'hA, 4'h5, 4'h9, 4'h3, 4'hE, 4'h6, 4'h3, 4'hF};

    // Clock/reset: release between edges so the first sample is the next rising edge
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i == reset_at) begin
        sin_valid = 1'b0; sync = 1'b0; bus.dout_ready = 1'b0; clr_ovf = 1'b0;
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({bus.dout, bus.dout_valid, busy, level, overflow} !== 9'h0) begin
          errors++;
          $display("FAIL async_reset {dout,dv,busy,level,ovf}: got %h/%b/%b/%0d/%b want 0/0/0/0/0",
                   bus.dout, bus.dout_valid, busy, level, overflow);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
      end
      step(vecs[i], i);
    end

    sin_valid = 1'b0; bus.dout_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pop_count: got %0d words still expected, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
